keypad_scanner: RTL and testbench

Scans a 4x4 calculator key matrix: drives one column low at a time, samples the rows, and debounces across whole scan frames. Emits a single-cycle press strobe with a 4-bit key code for each new key. Sits in the calculator input path, held in reset by the system reset-delay block's Reset output until the board has settled after configuration or a reset-button release.

---
 rtl/keypad_pkg.sv | 12 +
 rtl/keypad_debounce.sv | 82 ++++++++
 rtl/keypad_scanner.sv | 93 +++++++++
 tb/tb_keypad_scanner.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;
    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int KEY_W    = 4;

    typedef enum logic [1:0] {FR_NONE, FR_KEY, FR_MULTI} frame_result_t;

    function automatic logic [KEY_W-1:0] key_code(input logic [1:0] col, input logic [1:0] row);
        return {col, row};
    endfunction
endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: candidate/stable-count tracking, commit of key state, press strobe.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             eval_i,
    input  frame_result_t    result_i,
    input  logic [KEY_W-1:0] code_i,
    output logic [KEY_W-1:0] key_o,
    output logic             key_valid_o,
    output logic             key_held_o
);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] MAX = CW'(DEBOUNCE_SCANS);

    logic             cand_key_q, cand_key_d;
    logic [KEY_W-1:0] cand_code_q, cand_code_d;
    logic [CW-1:0]    stable_q, stable_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             held_q, held_d;
    logic             valid_q, valid_d;
    logic             res_key, same;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cand_key_q  <= 1'b0;
            cand_code_q <= '0;
            stable_q    <= '0;
            key_q       <= '0;
            held_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            cand_key_q  <= cand_key_d;
            cand_code_q <= cand_code_d;
            stable_q    <= stable_d;
            key_q       <= key_d;
            held_q      <= held_d;
            valid_q     <= valid_d;
        end
    end

    // Committed state is (held_q, key_q): key_q only carries meaning while held_q is set.
    always_comb begin
        cand_key_d  = cand_key_q;
        cand_code_d = cand_code_q;
        stable_d    = stable_q;
        key_d       = key_q;
        held_d      = held_q;
        valid_d     = 1'b0;
        res_key     = (result_i == FR_KEY);
        same        = 1'b0;
        if (eval_i) begin
            if (result_i == FR_MULTI) begin
                stable_d = '0;
            end else begin
                same = (res_key == cand_key_q) && (!res_key || code_i == cand_code_q);
                if (same) begin
                    if (stable_q != MAX) stable_d = stable_q + CW'(1);
                end else begin
                    cand_key_d  = res_key;
                    cand_code_d = code_i;
                    stable_d    = CW'(1);
                end
            end
            if (stable_d == MAX &&
                (cand_key_d != held_q || (cand_key_d && cand_code_d != key_q))) begin
                held_d = cand_key_d;
                if (cand_key_d) begin
                    key_d   = cand_code_d;
                    valid_d = 1'b1;
                end
            end
        end
    end

    assign key_o       = key_q;
    assign key_valid_o = valid_q;
    assign key_held_o  = held_q;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row synchronizer, column dwell/drive, per-frame intersection accumulation.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    output logic [NUM_COLS-1:0] Col,
    input  logic [NUM_ROWS-1:0] Row,
    output logic [KEY_W-1:0]    Key,
    output logic                KeyValid,
    output logic                KeyHeld
);
    localparam int DW = $clog2(SCAN_DIV);

    logic [NUM_ROWS-1:0] row_s1_q, row_s2_q;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic [1:0]          col_q, col_d;
    logic [1:0]          hits_q, hits_d;
    logic [KEY_W-1:0]    code_q, code_d;
    logic                eval_q, eval_d;
    logic                tick;
    logic [2:0]          pop, sum;
    logic [1:0]          ridx, base_hits;
    logic [KEY_W-1:0]    base_code;
    frame_result_t       frame_res;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            // Synchronizer clears to the released (pulled-up) level.
            row_s1_q <= '1;
            row_s2_q <= '1;
            dwell_q  <= '0;
            col_q    <= '0;
            hits_q   <= '0;
            code_q   <= '0;
            eval_q   <= 1'b0;
        end else begin
            row_s1_q <= Row;
            row_s2_q <= row_s1_q;
            dwell_q  <= dwell_d;
            col_q    <= col_d;
            hits_q   <= hits_d;
            code_q   <= code_d;
            eval_q   <= eval_d;
        end
    end

    // hits saturates at 2: anything beyond one intersection is simply MULTI.
    always_comb begin
        tick      = (dwell_q == DW'(SCAN_DIV - 1));
        dwell_d   = tick ? '0 : dwell_q + DW'(1);
        col_d     = tick ? col_q + 2'd1 : col_q;
        eval_d    = tick && (col_q == 2'd3);
        pop       = '0;
        ridx      = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (!row_s2_q[r]) begin
                pop  = pop + 3'd1;
                ridx = 2'(r);
            end
        end
        base_hits = (col_q == 2'd0) ? 2'd0 : hits_q;
        base_code = (col_q == 2'd0) ? '0 : code_q;
        sum       = {1'b0, base_hits} + pop;
        hits_d    = hits_q;
        code_d    = code_q;
        if (tick) begin
            hits_d = (sum >= 3'd2) ? 2'd2 : sum[1:0];
            code_d = (pop != 3'd0) ? key_code(col_q, ridx) : base_code;
        end
        case (hits_q)
            2'd0:    frame_res = FR_NONE;
            2'd1:    frame_res = FR_KEY;
            default: frame_res = FR_MULTI;
        endcase
    end

    assign Col = ~(NUM_COLS'(1) << col_q);

    keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .eval_i     (eval_q),
        .result_i   (frame_res),
        .code_i     (code_q),
        .key_o      (Key),
        .key_valid_o(KeyValid),
        .key_held_o (KeyHeld)
    );
endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: matrix model drives Row, expected key codes queued per press.
module tb_keypad_scanner;
    localparam int SD = 8;
    localparam int DS = 3;
    localparam int FR = 4 * SD;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  Col, Row, Key;
    logic        KeyValid, KeyHeld;
    logic [15:0] press = '0;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int kv_cyc = 0;
    int last_kv = 0;
    logic had_kv = 1'b0;
    logic [3:0] exp_q[$];

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .Clk(Clk), .Reset(Reset), .Col(Col), .Row(Row),
        .Key(Key), .KeyValid(KeyValid), .KeyHeld(KeyHeld)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Key index c*4+r pulls row r low while column c is driven.
    always_comb begin
        Row = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!Col[c])
                for (int r = 0; r < 4; r++)
                    if (press[c*4+r]) Row[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (KeyValid) begin
            if (had_kv) chk("kv_spacing", 32'(cyc - last_kv >= FR), 1);
            had_kv  = 1'b1;
            last_kv = cyc;
            kv_cyc  = cyc;
            if (exp_q.size() == 0) chk("kv_unexpected", 32'(KeyValid), 0);
            else begin
                chk("kv_key", 32'(Key), 32'(exp_q.pop_front()));
                chk("kv_held", 32'(KeyHeld), 1);
            end
        end
    end

    task automatic wait_frame();
        logic [3:0] prev;
        prev = Col;
        for (int i = 0; i < 2*FR; i++) begin
            @(negedge Clk);
            if (Col == 4'hE && prev == 4'h7) return;
            prev = Col;
        end
        chk("frame_sync_timeout", 32'({prev, Col}), 32'h7E);
    endtask

    task automatic wait_kv(input string tag, input int budget, output logic held_always);
        held_always = 1'b1;
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(negedge Clk); #1;
            if (!KeyHeld) held_always = 1'b0;
        end
        chk({tag, "_timeout"}, 32'(exp_q.size()), 0);
    endtask

    task automatic wait_held(input logic val, input int budget, output int lat);
        int t0;
        t0  = cyc;
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk); #1;
            if (KeyHeld == val) begin
                lat = cyc - t0;
                return;
            end
        end
        chk("held_timeout", 32'(KeyHeld), 32'(val));
    endtask

    task automatic release_all();
        int lat;
        wait_frame();
        press = '0;
        wait_held(1'b0, 6*FR, lat);
        chk($sformatf("release_lat=%0d", lat), 32'(lat >= 3*FR && lat <= 4*FR+4), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ha;
        int   t0, lat;
        logic [3:0] ec;

        // Reset state and idle column sweep
        repeat (3) @(negedge Clk);
        chk("rst_col", 32'(Col), 32'hE);
        chk("rst_key", 32'(Key), 0);
        chk("rst_held", 32'(KeyHeld), 0);
        chk("rst_kv", 32'(KeyValid), 0);
        Reset = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (k > 0) @(negedge Clk);
            ec = ~(4'b0001 << ((k / SD) % 4));
            chk($sformatf("idle_col@%0d", k), 32'(Col), 32'(ec));
        end
        chk("idle_key", 32'(Key), 0);
        chk("idle_held", 32'(KeyHeld), 0);

        // Clean press of key 6, then release
        wait_frame();
        t0 = cyc; press[6] = 1'b1; exp_q.push_back(4'd6);
        wait_kv("hold6", 6*FR, ha);
        lat = kv_cyc - t0;
        chk($sformatf("hold6_lat=%0d", lat), 32'(lat >= 3*FR && lat <= 4*FR+4), 1);
        repeat (2*FR) @(negedge Clk);
        chk("hold6_held", 32'(KeyHeld), 1);
        release_all();
        chk("rel6_key", 32'(Key), 6);

        // Bouncing key 6, then steady hold
        wait_frame();
        for (int i = 0; i < 20; i++) begin
            press[6] = (i % 2 == 0);
            repeat (5) @(negedge Clk);
        end
        t0 = cyc; press[6] = 1'b1; exp_q.push_back(4'd6);
        wait_kv("toggle6", 6*FR, ha);
        chk("toggle6_after_hold", 32'(kv_cyc > t0), 1);
        repeat (2*FR) @(negedge Clk);
        release_all();

        // Two keys at once: ghost rejection, then single key 0 remains
        wait_frame();
        press[0] = 1'b1; press[5] = 1'b1;
        repeat (5*FR) @(negedge Clk);
        chk("multi_held", 32'(KeyHeld), 0);
        wait_frame();
        t0 = cyc; press[5] = 1'b0; exp_q.push_back(4'd0);
        wait_kv("multi_rel", 6*FR, ha);
        lat = kv_cyc - t0;
        chk($sformatf("multi_rel_lat=%0d", lat), 32'(lat >= 3*FR && lat <= 4*FR+4), 1);
        release_all();

        // Key 3 committed, then direct switch to key 12
        wait_frame();
        t0 = cyc; press[3] = 1'b1; exp_q.push_back(4'd3);
        wait_kv("hold3", 6*FR, ha);
        lat = kv_cyc - t0;
        chk($sformatf("hold3_lat=%0d", lat), 32'(lat >= 3*FR && lat <= 4*FR+4), 1);
        wait_frame();
        t0 = cyc; press = 16'h1000; exp_q.push_back(4'd12);
        wait_kv("switch12", 6*FR, ha);
        chk("switch12_held_always", 32'(ha), 1);
        lat = kv_cyc - t0;
        chk($sformatf("switch12_lat=%0d", lat), 32'(lat >= 3*FR && lat <= 4*FR+4), 1);
        release_all();

        // Reset pulse two frames into debouncing key 9
        wait_frame();
        press[9] = 1'b1;
        repeat (2*FR + 10) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("rst9_col", 32'(Col), 32'hE);
        chk("rst9_key", 32'(Key), 0);
        chk("rst9_held", 32'(KeyHeld), 0);
        chk("rst9_kv", 32'(KeyValid), 0);
        t0 = cyc; exp_q.push_back(4'd9);
        wait_kv("rst9", 6*FR, ha);
        lat = kv_cyc - t0;
        chk($sformatf("rst9_lat=%0d", lat), 32'(lat >= 3*FR && lat <= 3*FR+4), 1);

        repeat (2*FR) @(negedge Clk);
        chk("final_queue", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
